// File: rtl/pll_lock_sequencer.sv
// Reference-clock sequencer for the system PLL: pulses the PLL reset, waits for synchronised lock,
// debounces it and releases the core reset, re-sequencing on lock loss or reconfig and latching FAIL.
module pll_lock_sequencer #(
  parameter int RST_PULSE    = 16,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int STABLE_CNT   = 1024,
  parameter int MAX_RETRY    = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       reconfig,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_cnt,
  output logic       lock_lost
);

  localparam int CNT_MAX = (LOCK_TIMEOUT > STABLE_CNT)
                         ? ((LOCK_TIMEOUT > RST_PULSE) ? LOCK_TIMEOUT : RST_PULSE)
                         : ((STABLE_CNT > RST_PULSE) ? STABLE_CNT : RST_PULSE);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  // The WAIT cycle that first sees lock is locked cycle one, so STABLE counts the remaining STABLE_CNT-1.
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CNT - 2);
  localparam logic [2:0]       RETRY_LAST   = 3'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    ST_PRST   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             sync_meta_r, lock_sync_r;
  logic [2:0]       retry_r, retry_s;
  logic             lock_lost_r, lock_lost_s;
  logic             attempt_fail_s;
  logic             pll_rst_r, sys_rst_r, ready_r, fail_r;
  logic             pll_rst_s, sys_rst_s, ready_s, fail_s;

  // Failed attempt: lock timeout in WAIT or lock dropping during debounce, unless reconfig wins
  always_comb begin
    attempt_fail_s = 1'b0;
    if (reconfig) begin
      attempt_fail_s = 1'b0;
    end else if (state_r == ST_WAIT) begin
      attempt_fail_s = !lock_sync_r && (cnt_r == TIMEOUT_LAST);
    end else if (state_r == ST_STABLE) begin
      attempt_fail_s = !lock_sync_r;
    end else begin
      attempt_fail_s = 1'b0;
    end
  end

  // Next state plus retry and lock-loss bookkeeping
  always_comb begin
    state_s     = state_r;
    retry_s     = retry_r;
    lock_lost_s = lock_lost_r;
    if (reconfig) begin
      state_s = ST_PRST;
      if (state_r == ST_FAIL) begin
        retry_s = 3'd0;
      end else begin
        retry_s = retry_r;
      end
    end else if (attempt_fail_s) begin
      retry_s = retry_r + 3'd1;
      if (retry_r == RETRY_LAST) begin
        state_s = ST_FAIL;
      end else begin
        state_s = ST_PRST;
      end
    end else begin
      case (state_r)
        ST_PRST: begin
          if (cnt_r == PULSE_LAST) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_PRST;
          end
        end
        ST_WAIT: begin
          if (lock_sync_r) begin
            state_s = ST_STABLE;
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_STABLE: begin
          if (cnt_r == STABLE_LAST) begin
            state_s = ST_RUN;
            retry_s = 3'd0;
          end else begin
            state_s = ST_STABLE;
          end
        end
        ST_RUN: begin
          if (!lock_sync_r) begin
            state_s     = ST_PRST;
            lock_lost_s = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_FAIL: state_s = ST_FAIL;
        default: state_s = ST_PRST;
      endcase
    end
  end

  // Shared phase counter: restarts on any transition or reconfig, idles at zero in RUN and FAIL
  always_comb begin
    cnt_s = CNT_ZERO;
    if (reconfig || (state_s != state_r)) begin
      cnt_s = CNT_ZERO;
    end else if ((state_r == ST_PRST) || (state_r == ST_WAIT) || (state_r == ST_STABLE)) begin
      cnt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_s = CNT_ZERO;
    end
  end

  // Output decode from the upcoming state so every output leaves a flop
  always_comb begin
    pll_rst_s = 1'b1;
    sys_rst_s = 1'b1;
    ready_s   = 1'b0;
    fail_s    = 1'b0;
    case (state_s)
      ST_PRST: begin
        pll_rst_s = 1'b1;
        sys_rst_s = 1'b1;
      end
      ST_WAIT, ST_STABLE: begin
        pll_rst_s = 1'b0;
        sys_rst_s = 1'b1;
      end
      ST_RUN: begin
        pll_rst_s = 1'b0;
        sys_rst_s = 1'b0;
        ready_s   = 1'b1;
      end
      ST_FAIL: begin
        pll_rst_s = 1'b1;
        sys_rst_s = 1'b1;
        fail_s    = 1'b1;
      end
      default: begin
        pll_rst_s = 1'b1;
        sys_rst_s = 1'b1;
      end
    endcase
  end

  // State, counter, lock synchroniser and output registers
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_PRST;
      cnt_r       <= CNT_ZERO;
      sync_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
      retry_r     <= 3'd0;
      lock_lost_r <= 1'b0;
      pll_rst_r   <= 1'b1;
      sys_rst_r   <= 1'b1;
      ready_r     <= 1'b0;
      fail_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      sync_meta_r <= locked;
      lock_sync_r <= sync_meta_r;
      retry_r     <= retry_s;
      lock_lost_r <= lock_lost_s;
      pll_rst_r   <= pll_rst_s;
      sys_rst_r   <= sys_rst_s;
      ready_r     <= ready_s;
      fail_r      <= fail_s;
    end
  end

  assign pll_rst   = pll_rst_r;
  assign sys_rst   = sys_rst_r;
  assign ready     = ready_r;
  assign fail      = fail_r;
  assign retry_cnt = retry_r;
  assign lock_lost = lock_lost_r;

  pll_lock_sequencer_chk #(
    .MAX_RETRY (MAX_RETRY)
  ) u_chk (
    .refclk    (refclk),
    .rst       (rst),
    .pll_rst   (pll_rst_r),
    .sys_rst   (sys_rst_r),
    .ready     (ready_r),
    .fail      (fail_r),
    .retry_cnt (retry_r)
  );

endmodule

// Output invariants of the sequencer: RUN is clean, FAIL holds everything in reset, retries stay bounded.
module pll_lock_sequencer_chk #(
  parameter int MAX_RETRY = 7
) (
  input logic       refclk,
  input logic       rst,
  input logic       pll_rst,
  input logic       sys_rst,
  input logic       ready,
  input logic       fail,
  input logic [2:0] retry_cnt
);

  a_ready_clean: assert property (@(posedge refclk) disable iff (rst)
    ready |-> (!sys_rst && !pll_rst));

  a_fail_held: assert property (@(posedge refclk) disable iff (rst)
    fail |-> (pll_rst && sys_rst && !ready));

  a_retry_bound: assert property (@(posedge refclk) disable iff (rst)
    retry_cnt <= 3'(MAX_RETRY));

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Power-up and recovery sequencer for the system PLL: 50 MHz reference in, 36 MHz core clock out, with a reset input and an asynchronous `locked` output.
- Drives the PLL reset and waits for lock with a timeout. Debounces lock, then releases the core reset.
- On loss of lock or a host reconfigure request, re-sequences the PLL. After repeated failures it flags a fatal condition.
- Sits at top level beside the PLL wrapper. Runs entirely on the free-running reference clock; downstream per-domain reset synchronisers are out of scope.

Parameters:
- RST_PULSE, 16, refclk cycles that pll_rst is held high per attempt (≥2).
- LOCK_TIMEOUT, 50000, refclk cycles allowed from pll_rst release to first synchronised lock (1 ms at 50 MHz).
- STABLE_CNT, 1024, consecutive synchronised-locked cycles required before releasing sys_rst.
- MAX_RETRY, 7, failed attempts tolerated before entering FAIL (1..7).

Ports:
- refclk in 1: free-running 50 MHz reference clock; the only clock.
- rst in 1: asynchronous, active-high reset.
- locked in 1: PLL lock, asynchronous to refclk.
- reconfig in 1: synchronous single-cycle request to restart the sequence.
- pll_rst out 1: reset to the PLL, active high.
- sys_rst out 1: core reset, active high, refclk domain.
- ready out 1: high only in RUN.
- fail out 1: sticky; high in FAIL.
- retry_cnt out 3: failed attempts since the last successful RUN entry.
- lock_lost out 1: sticky; set on the first lock drop seen in RUN, cleared only by rst.

Behaviour:
- All outputs are registered.
- Reset values: pll_rst=1, sys_rst=1, ready=0, fail=0, retry_cnt=0, lock_lost=0. State=PRST, counter=0, synchroniser=00.
- Lock synchronisation: locked passes through a 2-flop synchroniser to give lock_s. lock_s lags locked by 2 cycles. Only lock_s is used.
- Single counter, up to max(LOCK_TIMEOUT, STABLE_CNT, RST_PULSE) wide. Cleared on every state transition.
- PRST:
  - pll_rst=1, sys_rst=1.
  - When the counter reaches RST_PULSE-1, go to WAIT.
  - pll_rst therefore stays high for exactly RST_PULSE cycles.
- WAIT:
  - pll_rst=0, sys_rst=1.
  - If lock_s=1, go to STABLE.
  - Else, when the counter reaches LOCK_TIMEOUT-1, register an attempt failure.
- STABLE:
  - pll_rst=0, sys_rst=1.
  - When lock_s has been 1 for STABLE_CNT consecutive cycles, go to RUN. ready and sys_rst=0 appear on the cycle after the STABLE_CNT-th locked cycle.
  - If lock_s=0 at any point, register an attempt failure.
- RUN:
  - pll_rst=0, sys_rst=0, ready=1, retry_cnt cleared to 0 on entry.
  - If lock_s=0: set lock_lost and go to PRST. sys_rst and pll_rst are asserted the next cycle. retry_cnt is not incremented.
- Attempt failure handling:
  - If retry_cnt==MAX_RETRY-1: go to FAIL and increment retry_cnt.
  - Otherwise: increment retry_cnt and go to PRST.
- FAIL:
  - pll_rst=1, sys_rst=1, fail=1, ready=0.
  - Leaves only on rst or reconfig. On reconfig: clear fail and retry_cnt, go to PRST.
- reconfig:
  - In any state except PRST it forces PRST next cycle (and clears the counter). It does not change retry_cnt or lock_lost.
  - In PRST, it restarts the pulse count.
  - reconfig has priority over lock-loss and over timeout events in the same cycle.
- Asynchronous rst mid-operation returns everything to reset values immediately. It does not wait for a clock edge.
- The locked input is ignored in PRST and FAIL.

Test Plan:
- Use RST_PULSE=4, LOCK_TIMEOUT=20, STABLE_CNT=8, MAX_RETRY=3 for all scenarios.
- Nominal: release rst; assert locked 5 cycles after pll_rst falls. Required: pll_rst high exactly 4 cycles; sys_rst falls and ready rises exactly 2+8 cycles after the locked edge; retry_cnt=0.
- Timeout: locked held 0. Required:
  - 3 attempts, each 4 cycles pll_rst high then 20 low.
  - retry_cnt steps 1 → 2 → 3.
  - fail=1 with pll_rst=1 after the third timeout.
  - Then pulse reconfig: fail=0, retry_cnt=0, pll_rst pulse restarts.
- Glitchy lock: locked high 5 cycles, low 1, high steady. Required:
  - retry_cnt=1 and a new 4-cycle pll_rst pulse.
  - Then RUN after 8 stable cycles, with retry_cnt reset to 0.
- Loss in RUN: from RUN, drop locked for 3 cycles. Required:
  - sys_rst=1 and pll_rst=1 three cycles after the drop (2 sync + 1 register); lock_lost=1.
  - Relock reaches RUN with lock_lost still 1 and retry_cnt=0.
- Reconfig priority: in RUN, drop locked and pulse reconfig in the same lock_s cycle. Required:
  - PRST with retry_cnt unchanged.
  - reconfig during PRST cycle 2 extends pll_rst to 2+4 cycles.
- Async reset: assert rst mid-STABLE between clock edges. Required: all outputs at reset values before the next refclk edge.
